// File: rtl/fifo_savemod_p_if.sv
// fifo_savemod_p_if: port bundle for the fifo_savemod_p single-clock FIFO.
//
// Request/flag semantics (no valid/ready pair; the FIFO reports its state
// and the requester decides):
//   - iEn[1] is a write request. It is accepted on a rising edge when the
//     FIFO is not full, or when a read is accepted on that same edge.
//   - iEn[0] is a read request. It is accepted on a rising edge when the
//     FIFO is not empty.
//   - A request that is not accepted sets the matching sticky bit in oErr.
//   - iClear flushes on the next edge and overrides iEn in that cycle.
//   - oTag, oAlmost, oCount and oErr depend only on registered state, so
//     there is no combinational path from the request inputs.
// The requester uses the master modport and the FIFO uses the slave modport.
interface fifo_savemod_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic [1:0]        iEn;
    logic [DATA_W-1:0] iData;
    logic              iClear;
    logic [DATA_W-1:0] oData;
    logic [1:0]        oTag;
    logic [1:0]        oAlmost;
    logic [ADDR_W:0]   oCount;
    logic [1:0]        oErr;

    modport master (
        output iEn, iData, iClear,
        input  oData, oTag, oAlmost, oCount, oErr
    );

    modport slave (
        input  iEn, iData, iClear,
        output oData, oTag, oAlmost, oCount, oErr
    );
endinterface

// File: rtl/fifo_savemod_p.sv
// fifo_savemod_p: parametrised single-clock circular-buffer FIFO.
//
// Features:
//   - occupancy count
//   - almost-full and almost-empty flags
//   - sticky overflow and underflow flags
//   - synchronous flush
//
// Pointers are ADDR_W+1 bits wide. The low bits address the RAM and the MSB
// is the wrap bit, so full and empty can be told apart with no extra state.
//
// Optional build macro FIFO_SAVEMOD_FWFT_EN selects first-word fall-through.
// In that mode oData always shows the head word, and iEn[0] pops it.
// Without the macro, a read returns its word on oData one cycle after the
// read is accepted.
module fifo_savemod_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int AFULL_TH  = 1020,
    parameter int AEMPTY_TH = 4
) (
    input  logic           CLOCK,
    input  logic           RESET,
    fifo_savemod_p_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]   wr_q, wr_d;
    logic [ADDR_W:0]   rd_q, rd_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              empty, full;
    logic              rd_ok, wr_ok, clr;
    logic [ADDR_W:0]   count;
    int                count_i;
    logic              almost_full, almost_empty;

    // Status derived purely from the registered pointers
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[ADDR_W] != rd_q[ADDR_W]) &&
                   (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]);
    assign count = wr_q - rd_q;

    // A flush cycle accepts nothing and flags nothing
    assign clr   = bus.iClear;
    assign rd_ok = ~clr & bus.iEn[0] & ~empty;
    assign wr_ok = ~clr & bus.iEn[1] & (~full | rd_ok);

    // Threshold flags: signed integer compare, so out-of-range thresholds
    // simply pin the flag
    always_comb begin
        count_i      = {{(31 - ADDR_W){1'b0}}, count};
        almost_full  = (count_i >= AFULL_TH);
        almost_empty = (count_i <= AEMPTY_TH);
    end

    // Next-state for pointers, sticky errors and the read-data register
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        err_d  = err_q;
        data_d = data_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            err_d = '0;
        end else begin
            if (wr_ok) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (rd_ok) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (bus.iEn[1] && !wr_ok) begin
                err_d[1] = 1'b1;
            end
            if (bus.iEn[0] && !rd_ok) begin
                err_d[0] = 1'b1;
            end
`ifdef FIFO_SAVEMOD_FWFT_EN
            // Look-ahead: rd_d is the head address after this edge.
            // If rd_d equals the current write slot, the head is the word
            // being written now, so bypass the RAM. Otherwise take the head
            // from the RAM when the FIFO is non-empty after the edge.
            // When it is empty after the edge, hold the last value.
            if (wr_ok && (rd_d == wr_q)) begin
                data_d = bus.iData;
            end else if (rd_d != wr_d) begin
                data_d = mem_q[rd_d[ADDR_W-1:0]];
            end
`else
            // Registered read: the word appears one cycle after acceptance
            if (rd_ok) begin
                data_d = mem_q[rd_q[ADDR_W-1:0]];
            end
`endif
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_q   <= '0;
            rd_q   <= '0;
            err_q  <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
            data_q <= data_d;
        end
    end

    // Storage array: written on an accepted write and never reset
    always_ff @(posedge CLOCK) begin
        if (wr_ok) begin
            mem_q[wr_q[ADDR_W-1:0]] <= bus.iData;
        end
    end

    assign bus.oData   = data_q;
    assign bus.oTag    = {full, empty};
    assign bus.oAlmost = {almost_full, almost_empty};
    assign bus.oCount  = count;
    assign bus.oErr    = err_q;

endmodule

// File: tb/tb_fifo_savemod_p.sv
// tb_fifo_savemod_p: directed and randomized bench for fifo_savemod_p.
// The expected behaviour comes from a queue-based model of the FIFO rules.
module tb_fifo_savemod_p;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int AFULL_TH  = 14;
    localparam int AEMPTY_TH = 1;
    localparam int DEPTH     = 16;

    logic clk;
    logic rst;

    fifo_savemod_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fifo_savemod_p #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AFULL_TH (AFULL_TH),
        .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard and reference model state
    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        m_err;
    logic [DATA_W-1:0] m_data;
    int                n_total;
    int                n_pass;
    int                n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_err  = 2'b00;
        m_data = '0;
    endtask

    // The FIFO rules applied to one edge: pop first, then push
    task automatic model_step(input logic [1:0] en, input logic [DATA_W-1:0] d, input logic clr);
        bit rd_ok;
        bit wr_ok;
        if (clr) begin
            exp_q.delete();
            m_err = 2'b00;
        end else begin
            rd_ok = en[0] && (exp_q.size() > 0);
            wr_ok = en[1] && ((exp_q.size() < DEPTH) || rd_ok);
            if (en[1] && !wr_ok) m_err[1] = 1'b1;
            if (en[0] && !rd_ok) m_err[0] = 1'b1;
            if (rd_ok) begin
`ifdef FIFO_SAVEMOD_FWFT_EN
                void'(exp_q.pop_front());
`else
                m_data = exp_q.pop_front();
`endif
            end
            if (wr_ok) exp_q.push_back(d);
        end
`ifdef FIFO_SAVEMOD_FWFT_EN
        if (exp_q.size() > 0) m_data = exp_q[0];
`endif
    endtask

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        check("count",   32'(bus.oCount),  32'(n));
        check("tag",     32'(bus.oTag),    32'({(n == DEPTH), (n == 0)}));
        check("almost",  32'(bus.oAlmost), 32'({(n >= AFULL_TH), (n <= AEMPTY_TH)}));
        check("err",     32'(bus.oErr),    32'(m_err));
        check("data",    32'(bus.oData),   32'(m_data));
    endtask

    // One clock: drive inputs, apply the model at the edge, sample 1ns later
    task automatic cycle(input logic [1:0] en, input logic [DATA_W-1:0] d, input logic clr);
        bus.iEn    = en;
        bus.iData  = d;
        bus.iClear = clr;
        @(posedge clk);
        model_step(en, d, clr);
        #1;
        check_outputs();
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        n_fail     = 0;
        bus.iEn    = 2'b00;
        bus.iData  = '0;
        bus.iClear = 1'b0;
        rst        = 1'b0;
        model_reset();

        // Reset values, asserted asynchronously before any edge
        #1 rst = 1'b1;
        #2;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();

        // Fill 0x00..0x0F, then one write too many
        for (int i = 0; i < DEPTH; i++) cycle(2'b10, 8'(i), 1'b0);
        check("fill_tag", 32'(bus.oTag), 32'h2);
        cycle(2'b10, 8'hAA, 1'b0);
        check("ovf_err", 32'(bus.oErr), 32'h2);
        check("ovf_count", 32'(bus.oCount), 32'd16);

        // Drain, then one read too many
        for (int i = 0; i < DEPTH; i++) cycle(2'b01, 8'h00, 1'b0);
        check("drain_tag", 32'(bus.oTag), 32'h1);
        cycle(2'b01, 8'h00, 1'b0);
        check("udf_err", 32'(bus.oErr), 32'h3);
        check("udf_hold", 32'(bus.oData), 32'h0F);
        cycle(2'b00, 8'h00, 1'b1);

        // Simultaneous read and write while full
        for (int i = 0; i < DEPTH; i++) cycle(2'b10, 8'($urandom_range(0, 255)), 1'b0);
        cycle(2'b11, 8'h55, 1'b0);
        check("full_rw_count", 32'(bus.oCount), 32'd16);
        check("full_rw_err", 32'(bus.oErr), 32'h0);
        for (int i = 0; i < DEPTH; i++) cycle(2'b01, 8'h00, 1'b0);
        check("full_rw_last", 32'(bus.oData), 32'h55);

        // Wrap: streaming at a steady count of 3
        cycle(2'b00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle(2'b10, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 40; i++) cycle(2'b11, 8'($urandom_range(0, 255)), 1'b0);
        check("wrap_count", 32'(bus.oCount), 32'd3);
        for (int i = 0; i < 3; i++) cycle(2'b01, 8'h00, 1'b0);

        // Flush at count 9 with overflow pending, alongside both requests
        for (int i = 0; i < DEPTH + 1; i++) cycle(2'b10, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 7; i++) cycle(2'b01, 8'h00, 1'b0);
        check("pre_clr_count", 32'(bus.oCount), 32'd9);
        check("pre_clr_err", 32'(bus.oErr), 32'h2);
        cycle(2'b11, 8'h77, 1'b1);
        check("clr_count", 32'(bus.oCount), 32'd0);
        check("clr_err", 32'(bus.oErr), 32'h0);
        check("clr_tag", 32'(bus.oTag), 32'h1);

        // Single word through an empty FIFO
        cycle(2'b10, 8'h3C, 1'b0);
`ifdef FIFO_SAVEMOD_FWFT_EN
        check("fwft_head", 32'(bus.oData), 32'h3C);
`endif
        cycle(2'b01, 8'h00, 1'b0);
        check("pop_data", 32'(bus.oData), 32'h3C);
        check("pop_tag", 32'(bus.oTag), 32'h1);

        // Random traffic: write-heavy, then read-heavy, with rare flushes
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 80; i++) begin
                logic [1:0] en;
                int wp;
                wp = (ph % 2 == 0) ? 75 : 30;
                en[1] = ($urandom_range(0, 99) < wp);
                en[0] = ($urandom_range(0, 99) < (100 - wp));
                cycle(en, 8'($urandom_range(0, 255)), ($urandom_range(0, 59) == 0));
            end
        end

        // Reset asserted mid-burst, between edges
        for (int i = 0; i < 6; i++) cycle(2'b10, 8'($urandom_range(0, 255)), 1'b0);
        cycle(2'b11, 8'($urandom_range(0, 255)), 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // Post-reset behaviour matches a fresh start
        for (int i = 0; i < 40; i++) begin
            cycle(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b0);
        end

        bus.iEn    = 2'b00;
        bus.iClear = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_savemod_p.md
Name: fifo_savemod_p

Overview:
- Parametrised successor to the team's 8-bit/1024-deep sync FIFO: single-clock circular buffer with configurable data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and synchronous flush.
- Sits between SD-card sector engines and byte-stream producers/consumers, same slot as the existing save FIFO.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 10, address width; depth = 2**ADDR_W words
- AFULL_TH, 1020, oAlmost[1] asserts when count >= AFULL_TH
- AEMPTY_TH, 4, oAlmost[0] asserts when count <= AEMPTY_TH

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- iEn  in  2  [1]=write request, [0]=read request
- iData  in  DATA_W  write data, sampled on accepted write
- iClear  in  1  synchronous flush
- oData  out  DATA_W  read data
- oTag  out  2  [1]=full, [0]=empty
- oAlmost  out  2  [1]=almost full, [0]=almost empty
- oCount  out  ADDR_W+1  words stored, 0..2**ADDR_W
- oErr  out  2  sticky [1]=overflow, [0]=underflow

Behaviour:
- Clocking/reset: one clock CLOCK; RESET asynchronous, active-high.
- Reset values: pointers=0, oCount=0, oData=0, oErr=2'b00, oTag=2'b01, oAlmost=2'b01 (given AEMPTY_TH>=0). RAM contents not reset.
- Pointers: wr/rd pointers are ADDR_W+1 bits; low ADDR_W bits address RAM; MSB is the wrap bit.
- Flag logic:
  - empty = (wr==rd).
  - full = MSBs differ and low bits equal.
  - oCount = wr-rd, modulo 2**(ADDR_W+1).
- All flags and count reflect state after the most recent edge; no combinational path from iEn.
- Read acceptance: rd_ok = iEn[0] & !empty.
- Write acceptance: wr_ok = iEn[1] & (!full | rd_ok). A write while full is accepted only alongside an accepted read; count is unchanged.
- Simultaneous read+write while empty: write accepted, read rejected, underflow set, count goes 0->1.
- Accepted write: RAM[wr[ADDR_W-1:0]] <= iData; wr += 1.
- Accepted read: oData <= RAM[rd[ADDR_W-1:0]] (1-cycle latency); rd += 1. oData holds its value when there is no accepted read.
- Errors:
  - oErr[1] set on iEn[1] & !wr_ok.
  - oErr[0] set on iEn[0] & !rd_ok.
  - Both are sticky until RESET or iClear.
- iClear: next edge sets pointers=0 and oErr=0. oData is held and RAM is not cleared. iClear has priority over iEn in the same cycle; no error is flagged that cycle.
- Wrap-around: pointers roll over at 2**(ADDR_W+1) with no glitch in full, empty or count.
- Reset mid-operation: all in-flight state is discarded; post-reset behaviour equals a fresh start.
- Parameter rule: AFULL_TH and AEMPTY_TH are compared against the ADDR_W+1-bit oCount. Out-of-range thresholds simply pin the flag.

Optional Feature:
- Macro: FIFO_SAVEMOD_FWFT_EN.
- Defined (first-word fall-through):
  - oData continuously presents the head word while !empty; iEn[0] acts as pop/acknowledge.
  - After a write into an empty FIFO, empty deasserts and the word appears on oData at the same edge.
  - After a pop, the next word appears on oData at that edge.
  - Implemented with look-ahead read address rd_next.
  - oData is 0 after reset and holds its last value when empty.
- Undefined: standard 1-cycle registered read as above.

Test Plan (ADDR_W=4, DATA_W=8, AFULL_TH=14, AEMPTY_TH=1, non-FWFT unless stated):
- Fill: write 0x00..0x0F over 16 cycles -> oCount=16, oTag=2'b10, oAlmost[1]=1 from count 14. A 17th write (0xAA) -> oErr[1]=1, count stays 16, 0xAA never read back.
- Drain: 16 reads -> oData = 0x00..0x0F, each one cycle after its read; oTag=2'b01 afterwards. An extra read -> oErr[0]=1, oData holds 0x0F.
- Full with simultaneous read+write of 0x55 -> both accepted, count stays 16, no overflow; 0x55 emerges after the 15 older words.
- Wrap: 40 cycles of interleaved write/read at count 3 -> data in exact order, count stays 3, full/empty never assert.
- Clear/reset: at count 9 with oErr=2'b10, pulse iClear together with iEn=2'b11 -> next cycle count=0, oErr=0, empty=1. RESET asserted mid-burst -> all outputs return to reset values asynchronously.
- FWFT build: write 0x3C into empty FIFO -> oData=0x3C and empty=0 after that edge. Pop -> empty=1, oData holds 0x3C.
